// File: rtl/core_sequencer.sv
// Instruction sequencer for the core: fetch/decode/exec/mem/commit flow with
// interrupt entry, halt/resume and a retired-instruction counter.
module core_sequencer (
  input  logic        clk,
  input  logic        reset,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  output logic        o_ir_load,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic        i_halt_cmd,
  input  logic        i_rst_cmd,
  input  logic        i_return_cmd,
  input  logic        i_int_cmd,
  input  logic [1:0]  i_int_func,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  output logic        o_clk_en,
  output logic        o_soft_reset,
  input  logic        i_irq,
  output logic        o_int_taken,
  output logic        o_int_en,
  input  logic        i_resume,
  output logic        o_halted,
  output logic [15:0] o_retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_COMMIT, S_IRQ, S_HALT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_int_en, w_int_en_nxt;
  logic        r_pending, w_pending_nxt;
  logic [15:0] r_retired;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_int_en  <= 1'b0;
      r_pending <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_int_en  <= w_int_en_nxt;
      r_pending <= w_pending_nxt;
      if (r_state == S_COMMIT) r_retired <= r_retired + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_int_en_nxt  = r_int_en;
    w_pending_nxt = r_pending | i_irq;
    o_imem_req    = 1'b0;
    o_ir_load     = 1'b0;
    o_dmem_req    = 1'b0;
    o_dmem_we     = 1'b0;
    o_clk_en      = 1'b0;
    o_soft_reset  = 1'b0;
    o_int_taken   = 1'b0;
    o_halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_ir_load   = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (i_rst_cmd) begin
          o_soft_reset  = 1'b1;
          w_int_en_nxt  = 1'b0;
          w_pending_nxt = i_irq;
          w_state_nxt   = S_FETCH;
        end else if (i_halt_cmd) begin
          w_state_nxt = S_HALT;
        end else if (i_is_load || i_is_store) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = i_is_store;
        if (i_dmem_ack) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        o_clk_en = 1'b1;
        if (i_int_cmd) begin
          case (i_int_func)
            2'b00:   w_int_en_nxt  = 1'b0;
            2'b01:   w_int_en_nxt  = 1'b1;
            2'b10:   w_pending_nxt = 1'b1;
            default: ;
          endcase
        end
        if (i_return_cmd) w_int_en_nxt = 1'b1;
        // Decision uses post-commit enable/pending so a same-commit trigger or enable counts.
        w_state_nxt = (w_pending_nxt && w_int_en_nxt) ? S_IRQ : S_FETCH;
      end
      S_IRQ: begin
        o_int_taken   = 1'b1;
        w_int_en_nxt  = 1'b0;
        w_pending_nxt = i_irq;
        w_state_nxt   = S_FETCH;
      end
      S_HALT: begin
        o_halted = 1'b1;
        if (i_resume) w_state_nxt = S_COMMIT;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign o_int_en  = r_int_en;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized instruction stream against a transaction-level sequencer model;
// a negedge monitor matches every strobe against a scoreboard of expected events.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        o_imem_req, i_imem_ack, o_ir_load;
  logic        i_is_load, i_is_store, i_halt_cmd, i_rst_cmd, i_return_cmd, i_int_cmd;
  logic [1:0]  i_int_func;
  logic        o_dmem_req, o_dmem_we, i_dmem_ack;
  logic        o_clk_en, o_soft_reset, i_irq, o_int_taken, o_int_en, i_resume, o_halted;
  logic [15:0] o_retired;

  core_sequencer dut (
    .clk(clk), .reset(reset),
    .o_imem_req(o_imem_req), .i_imem_ack(i_imem_ack), .o_ir_load(o_ir_load),
    .i_is_load(i_is_load), .i_is_store(i_is_store), .i_halt_cmd(i_halt_cmd),
    .i_rst_cmd(i_rst_cmd), .i_return_cmd(i_return_cmd), .i_int_cmd(i_int_cmd),
    .i_int_func(i_int_func), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .i_dmem_ack(i_dmem_ack), .o_clk_en(o_clk_en), .o_soft_reset(o_soft_reset),
    .i_irq(i_irq), .o_int_taken(o_int_taken), .o_int_en(o_int_en),
    .i_resume(i_resume), .o_halted(o_halted), .o_retired(o_retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_IR = 0, K_CM = 1, K_SR = 2, K_IT = 3, K_BAD = 9;

  typedef struct packed {
    int kind; int cyc; int ret; int en; int nd; int nw; int nh; int nb;
  } ev_t;

  ev_t sb[$];
  int  tests = 0, fails = 0;
  bit  mon_en = 1'b0;
  int  m_ret, m_en, m_pend;
  int  n_d = 0, n_w = 0, n_h = 0, n_b = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: accumulates per-cycle observations, pops one expected event per strobe.
  always @(negedge clk) begin : mon
    int  ns;
    ev_t a, e;
    if (mon_en) begin
      ns = int'(o_ir_load) + int'(o_clk_en) + int'(o_soft_reset) + int'(o_int_taken);
      n_d += int'(o_dmem_req);
      n_w += int'(o_dmem_req && o_dmem_we);
      n_h += int'(o_halted);
      n_b += int'((o_imem_req && o_dmem_req) ||
                  (o_halted && (o_imem_req || o_dmem_req || ns != 0)));
      if (ns != 0) begin
        a.kind = (ns > 1) ? K_BAD : o_ir_load ? K_IR : o_clk_en ? K_CM :
                 o_soft_reset ? K_SR : K_IT;
        a.cyc = cyc; a.ret = int'(o_retired); a.en = int'(o_int_en);
        a.nd = n_d; a.nw = n_w; a.nh = n_h; a.nb = n_b;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL event: unexpected kind=%0d at cycle %0d, none expected", a.kind, a.cyc);
        end else begin
          e = sb.pop_front();
          if (a != e) begin
            fails++;
            $display("FAIL event: got kind=%0d cyc=%0d ret=%0d en=%0d nd=%0d nw=%0d nh=%0d nb=%0d expected kind=%0d cyc=%0d ret=%0d en=%0d nd=%0d nw=%0d nh=%0d nb=%0d",
                     a.kind, a.cyc, a.ret, a.en, a.nd, a.nw, a.nh, a.nb,
                     e.kind, e.cyc, e.ret, e.en, e.nd, e.nw, e.nh, e.nb);
          end
        end
        n_d = 0; n_w = 0; n_h = 0; n_b = 0;
      end
    end
  end

  // Apply inputs for the current cycle, then advance to just after the next edge.
  task automatic drive(input logic ia, input logic da);
    i_imem_ack = ia;
    i_dmem_ack = da;
    @(posedge clk);
    #1;
    i_irq    = 1'b0;
    i_resume = 1'b0;
  endtask

  function automatic logic sp();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic push(input int k, input int nd, input int nw, input int nh);
    ev_t e;
    e.kind = k; e.cyc = cyc; e.ret = m_ret; e.en = m_en;
    e.nd = nd; e.nw = nw; e.nh = nh; e.nb = 0;
    sb.push_back(e);
  endtask

  // Instruction kinds: 0 ALU, 1 LOAD, 2 STORE, 3 INT, 4 RETURN, 5 HALT, 6 RESET.
  task automatic set_flags(input int k, input int f);
    i_is_load    = (k == 1);
    i_is_store   = (k == 2);
    i_int_cmd    = (k == 3);
    i_int_func   = f[1:0];
    i_return_cmd = (k == 4);
    i_halt_cmd   = (k == 5);
    i_rst_cmd    = (k == 6);
  endtask

  task automatic garbage_flags();
    i_is_load    = 1'($urandom_range(0, 1));
    i_is_store   = 1'($urandom_range(0, 1));
    i_int_cmd    = 1'($urandom_range(0, 1));
    i_int_func   = 2'($urandom_range(0, 3));
    i_return_cmd = 1'($urandom_range(0, 1));
    i_halt_cmd   = 1'($urandom_range(0, 1));
    i_rst_cmd    = 1'($urandom_range(0, 1));
  endtask

  initial begin
    i_imem_ack = 0; i_dmem_ack = 0; i_irq = 0; i_resume = 0;
    set_flags(0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_imem_req", int'(o_imem_req), 1);
    chk("rst_dmem_req", int'(o_dmem_req), 0);
    chk("rst_clk_en", int'(o_clk_en), 0);
    chk("rst_ir_load", int'(o_ir_load), 0);
    chk("rst_halted", int'(o_halted), 0);
    chk("rst_int_en", int'(o_int_en), 0);
    chk("rst_retired", int'(o_retired), 0);
    m_ret = 0; m_en = 0; m_pend = 0;
    mon_en = 1'b1;

    for (int n = 0; n < 300; n++) begin
      int iw, ij, k, f, r, dw, hw, nd, nw, nh;
      iw = $urandom_range(0, 3);
      ij = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, iw)) : -1;
      r  = $urandom_range(0, 19);
      k  = (r < 5) ? 0 : (r < 8) ? 1 : (r < 10) ? 2 : (r < 14) ? 3 :
           (r < 16) ? 4 : (r < 18) ? 5 : 6;
      f  = $urandom_range(0, 3);
      for (int j = 0; j <= iw; j++) begin
        if (j == ij) begin i_irq = 1'b1; m_pend = 1; end
        if (j == iw) begin
          set_flags(k, f);
          push(K_IR, 0, 0, 0);
          drive(1'b1, sp());
        end else begin
          garbage_flags();
          drive(1'b0, sp());
        end
      end
      drive(sp(), sp());                       // decode
      if (k == 6) begin
        push(K_SR, 0, 0, 0);
        m_en = 0; m_pend = 0;
        drive(sp(), sp());
        continue;
      end
      drive(sp(), sp());                       // exec
      nd = 0; nw = 0; nh = 0;
      if (k == 5) begin
        hw = $urandom_range(1, 20);
        for (int h = 0; h <= hw; h++) begin
          if (h == hw) i_resume = 1'b1;
          if ($urandom_range(0, 7) == 0) begin i_irq = 1'b1; m_pend = 1; end
          drive(sp(), sp());
        end
        nh = hw + 1;
      end else if (k == 1 || k == 2) begin
        dw = $urandom_range(0, 3);
        for (int d = 0; d <= dw; d++) drive(sp(), d == dw);
        nd = dw + 1;
        nw = (k == 2) ? nd : 0;
      end
      push(K_CM, nd, nw, nh);
      if (k == 3) begin
        if (f == 0) m_en = 0;
        else if (f == 1) m_en = 1;
        else if (f == 2) m_pend = 1;
      end
      if (k == 4) m_en = 1;
      m_ret = (m_ret + 1) & 16'hFFFF;
      drive(sp(), sp());                       // commit
      if (m_en != 0 && m_pend != 0) begin
        push(K_IT, 0, 0, 0);
        m_en = 0; m_pend = 0;
        drive(sp(), sp());
      end
    end
    chk("sb_drain", sb.size(), 0);
    mon_en = 1'b0;

    // External reset while a load is waiting on its data ack; the ack in the reset cycle is dropped.
    set_flags(1, 0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk("mem_req_pre_reset", int'(o_dmem_req), 1);
    reset = 1'b1;
    drive(1'b0, 1'b1);
    reset = 1'b0;
    chk("mem_reset_dmem_req", int'(o_dmem_req), 0);
    chk("mem_reset_imem_req", int'(o_imem_req), 1);
    chk("mem_reset_retired", int'(o_retired), 0);
    chk("mem_reset_int_en", int'(o_int_en), 0);

    // External reset while halted.
    set_flags(5, 0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk("halt_pre_reset", int'(o_halted), 1);
    reset = 1'b1;
    drive(1'b0, 1'b0);
    reset = 1'b0;
    chk("halt_reset_halted", int'(o_halted), 0);
    chk("halt_reset_imem_req", int'(o_imem_req), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
